// File: rtl/flow_ctrl_fsm.sv
// Switch datapath control FSM: programs/validates per-FIFO watermarks, tracks idle/active/error.
// Optional FLOW_CTRL_ERR_RECOVER_EN lets init (with no live errors) leave ERROR back to INIT.
module flow_ctrl_fsm #(
  parameter int NUM_FIFOS = 5,
  parameter int TH_W      = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [NUM_FIFOS*TH_W-1:0] th_low_in,
  input  logic [NUM_FIFOS*TH_W-1:0] th_high_in,
  input  logic [NUM_FIFOS-1:0]      empties,
  input  logic [NUM_FIFOS-1:0]      errors,
  output logic [NUM_FIFOS*TH_W-1:0] th_low_out,
  output logic [NUM_FIFOS*TH_W-1:0] th_high_out,
  output logic [2:0]                state_out,
  output logic                      idle_out,
  output logic                      active_out,
  output logic                      error_out,
  output logic                      cfg_err,
  output logic [NUM_FIFOS-1:0]      err_src
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [NUM_FIFOS*TH_W-1:0]   th_low_q, th_low_d;
  logic [NUM_FIFOS*TH_W-1:0]   th_high_q, th_high_d;
  logic                        cfg_err_q, cfg_err_d;
  logic [NUM_FIFOS-1:0]        err_src_q, err_src_d;
  logic [NUM_FIFOS-1:0]        pair_ok;
  logic                        all_ok, any_err, all_empty, recover;

  // Validation looks at the captured (registered) thresholds, not the live inputs.
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_chk
    assign pair_ok[i] = th_low_q[i*TH_W +: TH_W] <= th_high_q[i*TH_W +: TH_W];
  end

  assign all_ok    = &pair_ok;
  assign any_err   = |errors;
  assign all_empty = &empties;

`ifdef FLOW_CTRL_ERR_RECOVER_EN
  assign recover = init && !any_err;
`else
  assign recover = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RESET;
      th_low_q  <= '0;
      th_high_q <= '0;
      cfg_err_q <= 1'b0;
      err_src_q <= '0;
    end else begin
      state_q   <= state_d;
      th_low_q  <= th_low_d;
      th_high_q <= th_high_d;
      cfg_err_q <= cfg_err_d;
      err_src_q <= err_src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!init) state_d = all_ok ? S_IDLE : S_ERROR;
      S_IDLE: begin
        if (any_err)         state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (!all_empty) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_err)        state_d = S_ERROR;
        else if (all_empty) state_d = S_IDLE;
      end
      S_ERROR:  if (recover) state_d = S_INIT;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    th_low_d  = th_low_q;
    th_high_d = th_high_q;
    cfg_err_d = cfg_err_q;
    err_src_d = err_src_q;
    if (state_q == S_RESET) begin
      th_low_d  = '0;
      th_high_d = '0;
    end
    if (state_q == S_INIT && init) begin
      th_low_d  = th_low_in;
      th_high_d = th_high_in;
    end
    if (state_q == S_INIT && !init && !all_ok) cfg_err_d = 1'b1;
    // Load on entry, accumulate while resident.
    if (state_d == S_ERROR)
      err_src_d = (state_q == S_ERROR) ? (err_src_q | errors) : errors;
    if (state_q == S_ERROR && state_d == S_INIT) begin
      err_src_d = '0;
      cfg_err_d = 1'b0;
    end
  end

  always_comb begin
    state_out   = state_q;
    idle_out    = (state_q == S_IDLE);
    active_out  = (state_q == S_ACTIVE);
    error_out   = (state_q == S_ERROR);
    th_low_out  = th_low_q;
    th_high_out = th_high_q;
    cfg_err     = cfg_err_q;
    err_src     = err_src_q;
  end

endmodule
